// File: rtl/cla_nibble_sequencer_if.sv
// rtl/cla_nibble_sequencer_if.sv - operand/result handshake bundle for cla_nibble_sequencer
// Overflow exists only when CLA_SEQ_OVF_EN is defined.
interface cla_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef CLA_SEQ_OVF_EN
  logic             Overflow;
`endif

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout
`ifdef CLA_SEQ_OVF_EN
    , input Overflow
`endif
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout
`ifdef CLA_SEQ_OVF_EN
    , output Overflow
`endif
  );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// rtl/cla_nibble_sequencer.sv - WIDTH-bit adder sequenced one nibble per clock through a 4-bit CLA slice
// Optional signed Overflow output enabled by CLA_SEQ_OVF_EN.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] s,
  output logic [3:0] g,
  output logic [3:0] p
);
  logic c1, c2, c3;

  assign g  = a & b;
  assign p  = a ^ b;
  assign c1 = g[0] | (p[0] & c);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
  assign s  = p ^ {c3, c2, c1, c};
endmodule

module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_nibble_sequencer_if.slave  bus
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [N-1:0][3:0]  a_q, b_q, sum_q;
  logic               carry, cout_q;
  logic [IW-1:0]      idx;
  logic [3:0]         s, g, p;
  logic               co, last, accept;
  logic               in_ready_c, out_valid_c;

  cla4_slice u_slice (
    .a (a_q[idx]),
    .b (b_q[idx]),
    .c (carry),
    .s (s),
    .g (g),
    .p (p)
  );

  // The slice exposes no carry-out, so the group carry is rebuilt from G/P here.
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & carry);
  assign last   = (idx == IW'(N - 1));
  assign accept = (state == IDLE) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef CLA_SEQ_OVF_EN
  logic c3, ovf_q;
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);

  always_ff @(posedge clk) begin
    if (rst)                             ovf_q <= 1'b0;
    else if ((state == RUN) && last)     ovf_q <= c3 ^ co;
  end

  assign bus.Overflow = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      a_q   <= bus.A;
      b_q   <= bus.B;
      carry <= bus.Cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_q[idx] <= s;
      carry      <= co;
      if (last) cout_q <= co;
      else      idx    <= idx + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// tb/tb_cla_nibble_sequencer.sv - self-checking bench for cla_nibble_sequencer
// Arithmetic model plus directed vectors with literal expectations.
module tb_cla_nibble_sequencer;
  localparam int W = 16;
  localparam int N = W / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_nibble_sequencer_if #(.WIDTH(W)) bus ();

  cla_nibble_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [W-1:0] q_sum[$];
  logic         q_cout[$];
  logic         q_ovf[$];
  int           q_acc[$];
  int           acc_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a result is plain integer addition of whatever was accepted.
  always @(posedge clk) begin
    logic [W:0] full;
    cyc++;
    if (rst) begin
      q_sum.delete(); q_cout.delete(); q_ovf.delete(); q_acc.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        full = {1'b0, bus.A} + {1'b0, bus.B} + {{W{1'b0}}, bus.Cin};
        q_sum.push_back(full[W-1:0]);
        q_cout.push_back(full[W]);
        q_ovf.push_back((bus.A[W-1] == bus.B[W-1]) && (full[W-1] != bus.A[W-1]));
        q_acc.push_back(cyc);
        acc_log.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready && q_sum.size() > 0) begin
        void'(q_sum.pop_front()); void'(q_cout.pop_front());
        void'(q_ovf.pop_front()); void'(q_acc.pop_front());
      end
    end
  end

  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        check("pending_result", q_sum.size() > 0, 1);
        if (q_sum.size() > 0) begin
          check("model_sum", bus.Sum, q_sum[0]);
          check("model_cout", bus.Cout, q_cout[0]);
`ifdef CLA_SEQ_OVF_EN
          check("model_ovf", bus.Overflow, q_ovf[0]);
`endif
          if (!prev_ov) check("latency", cyc - q_acc[0], N);
        end
        check("in_ready_in_done", bus.in_ready, 0);
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.A = a; bus.B = b; bus.Cin = c;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = ~a; bus.B = W'($urandom); bus.Cin = ~c;
  endtask

  task automatic wait_valid(input string name, input logic [W-1:0] es, input logic ec, input logic eo);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_sum"}, bus.Sum, es);
    check({name, "_cout"}, bus.Cout, ec);
`ifdef CLA_SEQ_OVF_EN
    check({name, "_ovf"}, bus.Overflow, eo);
`else
    if (eo === 1'bx) check({name, "_ovf_arg"}, eo, 0);
`endif
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] es, input logic ec, input logic eo);
    wait_valid(name, es, ec, eo);
    @(negedge clk);
  endtask

  typedef struct { logic [W-1:0] a, b; logic c; logic [W-1:0] s; logic co, ov; } vec_t;
  vec_t vecs[4];
  logic [W-1:0] hold;
  int n_acc;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.Sum, 16'h0000);
    check("rst_cout", bus.Cout, 0);
`ifdef CLA_SEQ_OVF_EN
    check("rst_ovf", bus.Overflow, 0);
`endif

    send(16'h1234, 16'h4321, 1'b0);
    wait_result("basic", 16'h5555, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    check("throughput", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], N + 2);
    wait_result("ripple", 16'h0000, 1'b1, 1'b0);

    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[1] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h00F0, 16'h0F10, 1'b1, 16'h1001, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].c);
      wait_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov);
    end

    bus.out_ready = 1'b0;
    send(16'hABCD, 16'h1111, 1'b0);
    wait_valid("bp", 16'hBCDE, 1'b0, 1'b0);
    hold = bus.Sum;
    bus.in_valid = 1'b1; bus.A = 16'h0F0F; bus.B = 16'h0101; bus.Cin = 1'b1;
    n_acc = acc_log.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_sum_stable", bus.Sum, hold);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
    end
    check("bp_no_accept", acc_log.size(), n_acc);
    bus.out_ready = 1'b1;
    send(16'h0F0F, 16'h0101, 1'b1);
    check("bp_next_accept", acc_log.size(), n_acc + 1);
    wait_result("bp_next", 16'h1011, 1'b0, 1'b0);

    send(16'hAAAA, 16'h5555, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_sum", bus.Sum, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_result", bus.out_valid, 0);
    end
    send(16'h0001, 16'h0001, 1'b0);
    wait_result("after_abort", 16'h0002, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
